// File: rtl/fifo_stream_reader.sv
// Read-side FIFO consumer: pops entries with 1-cycle read latency into a two-entry
// buffer and presents them as a packetised valid/ready stream with a packet counter.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  idle,
  output logic [1:0]            dbg_state
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } buf_state_t;

  buf_state_t            state, state_nxt;
  logic                  in_flight;
  logic [DATA_WIDTH-1:0] skid_data, skid_nxt, data_nxt;
  logic [BW-1:0]         beat_cnt;
  logic                  pop;
  logic [1:0]            held;
  logic [2:0]            occ;

  // Stream handshake: a beat transfers on a cycle where m_valid & m_ready are both
  // high; once m_valid rises, m_data/m_last hold until that transfer happens.
  assign pop       = m_valid & m_ready;
  assign m_valid   = (state != S_EMPTY);
  assign m_last    = m_valid & (beat_cnt == LAST_BEAT);
  assign idle      = (state == S_EMPTY) & ~in_flight;
  assign dbg_state = state;

  // Occupancy counts the in-flight read so the buffer can never be overrun.
  assign held = (state == S_TWO) ? 2'd2 : (state == S_ONE) ? 2'd1 : 2'd0;
  assign occ  = {1'b0, held} + {2'b0, in_flight};
  assign fifo_rd_en = rd_rst_n & enable & ~fifo_rd_empty & (occ < (3'd2 + {2'b0, pop}));

  always_comb begin
    state_nxt = state;
    data_nxt  = m_data;
    skid_nxt  = skid_data;
    case (state)
      S_EMPTY: begin
        if (in_flight) begin
          state_nxt = S_ONE;
          data_nxt  = fifo_rd_data;
        end
      end
      S_ONE: begin
        if (in_flight && pop) begin
          data_nxt = fifo_rd_data;
        end else if (in_flight) begin
          state_nxt = S_TWO;
          skid_nxt  = fifo_rd_data;
        end else if (pop) begin
          state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        // A capture while full without a pop cannot occur: reads stop at occupancy 2.
        if (pop) begin
          data_nxt = skid_data;
          if (in_flight) skid_nxt = fifo_rd_data;
          else           state_nxt = S_ONE;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state     <= S_EMPTY;
      in_flight <= 1'b0;
      m_data    <= '0;
      skid_data <= '0;
      beat_cnt  <= '0;
      pkt_count <= '0;
    end else begin
      state     <= state_nxt;
      in_flight <= fifo_rd_en;
      m_data    <= data_nxt;
      skid_data <= skid_nxt;
      if (pop) begin
        if (m_last) begin
          beat_cnt  <= '0;
          pkt_count <= pkt_count + CNT_WIDTH'(1);
        end else begin
          beat_cnt  <= beat_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: two instances (8-beat packets, and 1-beat packets with a
// 2-bit counter) each fed by a queue-based FIFO model and checked against a scoreboard.
module tb_fifo_stream_reader;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, m_ready;

  logic          rd_en0, mv0, ml0, idle0;
  logic          empty0 = 1'b1;
  logic [DW-1:0] rdata0 = '0;
  logic [DW-1:0] md0;
  logic [15:0]   pc0;
  logic [1:0]    st0;

  logic          rd_en1, mv1, ml1, idle1;
  logic          empty1 = 1'b1;
  logic [DW-1:0] rdata1 = '0;
  logic [DW-1:0] md1;
  logic [1:0]    pc1;
  logic [1:0]    st1;

  logic          push0_v = 1'b0, push1_v = 1'b0;
  logic [DW-1:0] push0_d = '0, push1_d = '0;
  logic [DW-1:0] fq0[$], fq1[$];

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(8), .CNT_WIDTH(16)) dut0 (
    .rd_clk(clk), .rd_rst_n(rst_n), .enable(enable), .fifo_rd_en(rd_en0),
    .fifo_rd_data(rdata0), .fifo_rd_empty(empty0), .m_valid(mv0), .m_ready(m_ready),
    .m_data(md0), .m_last(ml0), .pkt_count(pc0), .idle(idle0), .dbg_state(st0)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1), .CNT_WIDTH(2)) dut1 (
    .rd_clk(clk), .rd_rst_n(rst_n), .enable(enable), .fifo_rd_en(rd_en1),
    .fifo_rd_data(rdata1), .fifo_rd_empty(empty1), .m_valid(mv1), .m_ready(m_ready),
    .m_data(md1), .m_last(ml1), .pkt_count(pc1), .idle(idle1), .dbg_state(st1)
  );

  // FIFO models: registered read data one cycle after an accepted read
  always @(posedge clk) begin
    if (rd_en0 && !empty0 && fq0.size() > 0) rdata0 <= fq0.pop_front();
    if (push0_v) fq0.push_back(push0_d);
    empty0 <= (fq0.size() == 0);
  end

  always @(posedge clk) begin
    if (rd_en1 && !empty1 && fq1.size() > 0) rdata1 <= fq1.pop_front();
    if (push1_v) fq1.push_back(push1_d);
    empty1 <= (fq1.size() == 0);
  end

  // Scoreboard: words accepted from the FIFO, in order, with the first cycle they may show
  typedef struct {
    logic [DW-1:0] data;
    int            ready_at;
  } exp_t;

  exp_t exp_q0[$], exp_q1[$];
  int   n_deliv[2];
  int   exp_pkt[2];
  int   tests = 0;
  int   fails = 0;
  int   neg_idx = 0;
  logic [15:0] pcx;

  typedef struct {
    int            lane;
    int            n_words;
    logic [DW-1:0] base;
    int            stall;
    logic [15:0]   exp_pkt;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_lane(input int lane);
    logic v, l, re, id, em;
    logic [DW-1:0] d, front;
    logic [15:0] pc;
    exp_t q[$];
    int n, pk, plen, mask;
    bit ev, pop;
    string tag;
    if (lane == 0) begin
      v = mv0; l = ml0; re = rd_en0; id = idle0; em = empty0; d = md0; pc = pc0;
      q = exp_q0; front = (fq0.size() > 0) ? fq0[0] : '0; plen = 8; mask = 'hFFFF;
    end else begin
      v = mv1; l = ml1; re = rd_en1; id = idle1; em = empty1; d = md1; pc = {14'b0, pc1};
      q = exp_q1; front = (fq1.size() > 0) ? fq1[0] : '0; plen = 1; mask = 3;
    end
    tag = $sformatf("lane%0d", lane);
    n  = n_deliv[lane];
    pk = exp_pkt[lane];
    if (!rst_n) begin
      chk({tag, "_rst_valid"}, v, 0);
      chk({tag, "_rst_data"}, d, 0);
      chk({tag, "_rst_last"}, l, 0);
      chk({tag, "_rst_idle"}, id, 1);
      chk({tag, "_rst_rd_en"}, re, 0);
      chk({tag, "_rst_pkt"}, pc, 0);
      q.delete();
      n = 0;
      pk = 0;
    end else begin
      ev  = (q.size() > 0) && (q[0].ready_at <= neg_idx);
      pop = ev && m_ready;
      chk({tag, "_valid"}, v, ev);
      chk({tag, "_idle"}, id, q.size() == 0);
      chk({tag, "_pkt"}, pc, pk);
      chk({tag, "_rd_en"}, re, enable && !em && ((q.size() - int'(pop)) < 2));
      if (ev) begin
        chk({tag, "_data"}, d, q[0].data);
        chk({tag, "_last"}, l, (n % plen) == (plen - 1));
      end
      if (pop) begin
        if ((n % plen) == (plen - 1)) pk = (pk + 1) & mask;
        n++;
        void'(q.pop_front());
      end
      if (re && !em) q.push_back('{front, neg_idx + 2});
    end
    if (lane == 0) exp_q0 = q;
    else           exp_q1 = q;
    n_deliv[lane] = n;
    exp_pkt[lane] = pk;
  endtask

  task automatic step();
    @(negedge clk);
    check_lane(0);
    check_lane(1);
    neg_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int lane, input logic [DW-1:0] w);
    if (lane == 0) begin push0_v = 1'b1; push0_d = w; end
    else           begin push1_v = 1'b1; push1_d = w; end
    step();
    push0_v = 1'b0;
    push1_v = 1'b0;
  endtask

  function automatic bit busy();
    return (fq0.size() > 0) || (exp_q0.size() > 0) || (fq1.size() > 0) || (exp_q1.size() > 0);
  endfunction

  task automatic drain(input string name);
    for (int t = 0; t < 300 && busy(); t++) step();
    chk({name, "_drained"}, busy(), 0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{lane: 0, n_words: 8,  base: 32'h10, stall: 0, exp_pkt: 16'd1};
    vecs[1] = '{lane: 0, n_words: 3,  base: 32'h20, stall: 0, exp_pkt: 16'd1};
    vecs[2] = '{lane: 0, n_words: 5,  base: 32'h30, stall: 5, exp_pkt: 16'd2};
    vecs[3] = '{lane: 1, n_words: 5,  base: 32'h40, stall: 0, exp_pkt: 16'd1};
    vecs[4] = '{lane: 0, n_words: 17, base: 32'h50, stall: 0, exp_pkt: 16'd4};

    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
    step();
    chk("reset_valid", mv0, 0);
    chk("reset_idle", idle0, 1);
    chk("reset_pkt", pc0, 0);
    rst_n = 1'b1;
    step();

    // Empty FIFO, then a single word: two-cycle latency, not a packet end
    enable = 1'b1; m_ready = 1'b1;
    repeat (8) step();
    chk("empty_no_rd_en", rd_en0, 0);
    push(0, 32'hA5);
    for (int t = 0; t < 5 && !rd_en0; t++) step();
    chk("a5_rd_en", rd_en0, 1);
    step();
    chk("a5_in_flight_valid", mv0, 0);
    step();
    chk("a5_valid", mv0, 1);
    chk("a5_data", md0, 32'hA5);
    chk("a5_last", ml0, 0);
    drain("a5");

    // Reset while two entries are buffered and a third waits in the FIFO
    m_ready = 1'b0;
    push(0, 32'h61);
    push(0, 32'h62);
    push(0, 32'h63);
    repeat (4) step();
    chk("pre_rst_valid", mv0, 1);
    chk("pre_rst_data", md0, 32'h61);
    chk("pre_rst_rd_en", rd_en0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_now_valid", mv0, 0);
    chk("rst_now_data", md0, 0);
    chk("rst_now_idle", idle0, 1);
    step();
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int t = 0; t < 6 && !mv0; t++) step();
    chk("post_rst_data", md0, 32'h63);
    chk("post_rst_last", ml0, 0);
    drain("post_rst");
    reset_dut();

    for (int r = 0; r < 5; r++) begin
      enable = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < vecs[r].n_words; i++) begin
        push(vecs[r].lane, vecs[r].base + DW'(i));
        if (i == 2 && vecs[r].stall > 0) begin
          m_ready = 1'b0;
          repeat (vecs[r].stall) step();
          chk("bp_rd_en", rd_en0, 0);
          chk("bp_valid", mv0, 1);
          chk("bp_data", md0, vecs[r].base);
          m_ready = 1'b1;
        end
      end
      drain($sformatf("vec%0d", r));
      pcx = (vecs[r].lane == 0) ? pc0 : {14'b0, pc1};
      chk($sformatf("vec%0d_pkt", r), pcx, vecs[r].exp_pkt);
      chk($sformatf("vec%0d_idle", r), (vecs[r].lane == 0) ? idle0 : idle1, 1);
    end

    // enable dropped with two entries held; packet resumes afterwards
    reset_dut();
    enable = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(0, 32'h70 + DW'(i));
    enable = 1'b1;
    repeat (4) step();
    chk("t4_held_valid", mv0, 1);
    chk("t4_held_rd_en", rd_en0, 0);
    enable = 1'b0; m_ready = 1'b1;
    repeat (4) step();
    chk("t4_drained_valid", mv0, 0);
    chk("t4_no_rd_en", rd_en0, 0);
    chk("t4_mid_pkt", pc0, 0);
    enable = 1'b1;
    drain("t4");
    chk("t4_pkt", pc0, 1);

    // Randomized traffic on both lanes with occasional resets
    for (int c = 0; c < 1500; c++) begin
      enable  = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      push0_v = ($urandom_range(0, 1) == 1) && (fq0.size() < 6);
      push0_d = $urandom();
      push1_v = ($urandom_range(0, 1) == 1) && (fq1.size() < 6);
      push1_d = $urandom();
      rst_n   = ($urandom_range(0, 299) != 0);
      step();
    end
    push0_v = 1'b0; push1_v = 1'b0;
    rst_n = 1'b1; enable = 1'b1; m_ready = 1'b1;
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
